// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style pipeline front end: opcode field,
// NOP encoding, default reset PC and fetch FSM encoding.
package mips_pkg;

    localparam int unsigned OP_MSB = 31;
    localparam int unsigned OP_LSB = 26;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    typedef enum logic [1:0] {
        ST_FETCH = FETCH,
        ST_WAIT  = WAIT,
        ST_HOLD  = HOLD
    } fetch_state_e;

endpackage

// File: rtl/if_skid_buf.sv
// Single-entry {instr, pc} holding buffer used when a fetch response returns
// while the IF/ID register is stalled.
module if_skid_buf
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              unload,
    input  logic              clear,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [ADDR_W-1:0] in_pc,
    output logic              full,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            full      <= 1'b0;
            out_instr <= DATA_W'(NOP_INSTR);
            out_pc    <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full      <= 1'b1;
            out_instr <= in_instr;
            out_pc    <= in_pc;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem fetch and IF/ID register.
// Define IF_PERF_CNT_EN to add the fetch/stall performance counters.
module if_fetch_stage
    import mips_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              id_stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [5:0]        if_opcode,
    output logic [ADDR_W-1:0] if_pc,
`ifdef IF_PERF_CNT_EN
    output logic [ADDR_W-1:0] if_pc_plus4,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`else
    output logic [ADDR_W-1:0] if_pc_plus4
`endif
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);

    fetch_state_e      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_pc;
    logic              drop;

    logic              slot_free;
    logic              handshake;
    logic              rsp_ok;
    logic              load_rsp;
    logic              to_skid;
    logic              unload_skid;
    logic              in_flight;

    logic              skid_full;
    logic [DATA_W-1:0] skid_instr;
    logic [ADDR_W-1:0] skid_pc;

    assign slot_free = !if_valid || !id_stall;
    assign imem_req  = !rst && (state == ST_FETCH) && slot_free && !skid_full;
    assign imem_addr = pc & ALIGN_MASK;
    assign handshake = imem_req && imem_gnt;

    // Redirect outranks any response arriving in the same cycle.
    assign rsp_ok      = (state == ST_WAIT) && imem_rvalid && !drop;
    assign load_rsp    = !redirect && rsp_ok && slot_free;
    assign to_skid     = !redirect && rsp_ok && !slot_free;
    assign unload_skid = !redirect && (state == ST_HOLD) && !id_stall;

    // A request still owes a response after this edge.
    assign in_flight = ((state == ST_WAIT) && !imem_rvalid) || handshake;

    assign if_opcode = if_instr[OP_MSB:OP_LSB];

    if_skid_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (to_skid),
        .unload    (unload_skid),
        .clear     (redirect),
        .in_instr  (imem_rdata),
        .in_pc     (req_pc),
        .full      (skid_full),
        .out_instr (skid_instr),
        .out_pc    (skid_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_FETCH;
            pc          <= RESET_PC & ALIGN_MASK;
            req_pc      <= '0;
            drop        <= 1'b0;
            if_valid    <= 1'b0;
            if_instr    <= DATA_W'(NOP_INSTR);
            if_pc       <= '0;
            if_pc_plus4 <= '0;
        end else if (redirect) begin
            pc       <= redirect_pc & ALIGN_MASK;
            if_valid <= 1'b0;
            drop     <= in_flight;
            state    <= in_flight ? ST_WAIT : ST_FETCH;
        end else begin
            unique case (state)
                ST_FETCH: begin
                    if (handshake) begin
                        req_pc <= pc;
                        pc     <= pc + PC_STEP;
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= ST_FETCH;
                        end else begin
                            state <= slot_free ? ST_FETCH : ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!id_stall) state <= ST_FETCH;
                end
                default: state <= ST_FETCH;
            endcase

            if (load_rsp) begin
                if_valid    <= 1'b1;
                if_instr    <= imem_rdata;
                if_pc       <= req_pc;
                if_pc_plus4 <= req_pc + PC_STEP;
            end else if (unload_skid) begin
                if_valid    <= 1'b1;
                if_instr    <= skid_instr;
                if_pc       <= skid_pc;
                if_pc_plus4 <= skid_pc + PC_STEP;
            end else if (!id_stall) begin
                if_valid <= 1'b0;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (rsp_ok && !redirect) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (if_valid && id_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage: owns the PC, issues word fetches to instruction memory, and presents instruction/PC to decode.
- Output register acts as the IF/ID pipeline register; `if_opcode` drives the control unit's `op` input directly.
- Handles variable-latency imem, decode stalls and EX-stage redirects (branch/jump).
- One outstanding imem request maximum.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC/imem address width.
- DATA_W, 32, instruction width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- imem_req  out  1  fetch request valid.
- imem_addr  out  ADDR_W  fetch address, word aligned (bits [1:0] always 0).
- imem_gnt  in  1  imem accepts request this cycle (req & gnt = handshake).
- imem_rvalid  in  1  response valid; exactly one per granted request, ≥1 cycle after grant.
- imem_rdata  in  DATA_W  instruction word.
- id_stall  in  1  decode cannot accept; hold IF/ID.
- redirect  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  ADDR_W  new PC; bits [1:0] forced to 0.
- if_valid  out  1  IF/ID contents valid.
- if_instr  out  DATA_W  instruction.
- if_opcode  out  6  if_instr[31:26], to control op.
- if_pc  out  ADDR_W  address of if_instr.
- if_pc_plus4  out  ADDR_W  if_pc + 4, modulo 2^ADDR_W.

Behaviour:
- Reset:
  - pc=RESET_PC, state=FETCH, imem_req=0.
  - if_valid=0, if_instr=32'h0 (NOP), if_pc=0, if_pc_plus4=0.
  - skid empty, drop flag=0.
- FSM states:
  - FETCH: imem_req=1 when output slot is free, i.e. (!if_valid | !id_stall) and skid empty.
    - On req&gnt: latch req_pc=pc, pc<=pc+4, go to WAIT.
  - WAIT: imem_req=0. On rvalid:
    - If drop=1: discard the response, clear drop, go to FETCH.
    - Else if the output register can load (!if_valid | !id_stall): load if_instr=rdata, if_pc=req_pc, if_pc_plus4=req_pc+4, if_valid=1; go to FETCH.
    - Else: write the response to skid, go to HOLD.
  - HOLD: skid full, imem_req=0. When !id_stall: move skid to output, empty skid, go to FETCH.
- Decode handshake:
  - With !id_stall and no new word arriving, if_valid<=0 next cycle (bubble).
  - With id_stall, all if_* outputs hold.
- Redirect (highest priority over stall, response and grant in the same cycle):
  - pc<=redirect_pc&~3.
  - if_valid<=0, skid cleared.
  - If a request is in flight (WAIT, or granted this cycle), drop<=1 and the state is WAIT; else state is FETCH.
  - First fetch at the new PC is issued no earlier than the cycle after redirect.
- Latency: with zero-wait imem (rvalid the cycle after gnt), a fetch appears on if_valid 2 cycles after req&gnt. Sustained throughput is 1 instruction per 2 cycles; the single-outstanding limit is intentional.
- PC wrap: 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- Reset mid-WAIT: the pending response returns after rst deasserts while state=FETCH. Imem contract: imem is reset together with this block, so no stale rvalid occurs.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0 and wrapping.
  - perf_fetch_cnt increments on each non-dropped response.
  - perf_stall_cnt increments each cycle with if_valid & id_stall.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package mips_pkg:
  - opcode field constants (OP_MSB=31, OP_LSB=26);
  - NOP_INSTR=32'h0;
  - default RESET_PC;
  - FSM encoding localparams FETCH/WAIT/HOLD (2-bit).
- One sub-module if_skid_buf: single-entry buffer {instr, pc} with load/unload/clear and full flag.

Test Plan:
- Reset release with RESET_PC=0 and imem answering the cycle after gnt: expect if_pc sequence 0x0, 0x4, 0x8; if_opcode=rdata[31:26]; if_pc_plus4=if_pc+4.
- Hold id_stall=1 for 5 cycles while a response for pc 0x8 arrives: expect the skid to capture it; outputs frozen at pc 0x4; imem_req=0. After release, pc 0x8 is on outputs the next cycle and no instruction is lost or duplicated.
- Redirect to 0x100 while WAIT on pc 0xC: expect the 0xC response dropped, if_valid=0, and the next imem_addr=0x100.
- Redirect to 0x203 with simultaneous rvalid and id_stall: expect imem_addr=0x200, the response discarded, and if_valid=0.
- Start from PC 0xFFFF_FFFC: expect if_pc_plus4=0 and the next fetch address 0x0.
- With IF_PERF_CNT_EN: 10 fetches and a 3-cycle stall give perf_fetch_cnt=10 and perf_stall_cnt=3. Without the macro the bench compiles without the counter ports.
